// File: rtl/btn_pkg.sv
// Shared types and width helpers for the push-button step-pulse conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESS_CHK = 2'b01,
        PRESSED   = 2'b10,
        REL_CHK   = 2'b11
    } btn_state_t;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_step_pulse_sync_chain.sv
// Generic 1-bit multi-flop synchronizer, reusable for any asynchronous board input.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/btn_step_pulse.sv
// Push-button conditioner: synchronizer, debounce FSM and hold-to-repeat, producing
// one-cycle step strobes plus a debounced level and a wrapping pulse count.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | button released and stable
// PRESS_CHK | synchronized level high, waiting for it to stay stable
// PRESSED   | press accepted; auto-repeat timer runs if enabled
// REL_CHK   | synchronized level low, waiting for release to be stable
module btn_step_pulse
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int REPEAT_DELAY    = 100000000,
    parameter int REPEAT_PERIOD   = 20000000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             repeat_en,
    output logic             step_pulse,
    output logic             btn_level,
    output logic [CNT_W-1:0] press_count
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic             s;
    btn_state_t       state_q, state_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic             rep_first_q, rep_first_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] count_q, count_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (btn_in),
        .q_o   (s)
    );

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        rcnt_d      = rcnt_q;
        rep_first_d = rep_first_q;
        pulse_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_CHK;
                    dcnt_d  = '0;
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (dcnt_q == DB_LAST) begin
                    state_d     = PRESSED;
                    pulse_d     = 1'b1;
                    rcnt_d      = '0;
                    rep_first_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            PRESSED: begin
                // A falling level beats a coinciding repeat expiry: rcnt stays frozen.
                if (!s) begin
                    state_d = REL_CHK;
                    dcnt_d  = '0;
                end else if (repeat_en) begin
                    if (rcnt_q == (rep_first_q ? PER_LAST : DLY_LAST)) begin
                        pulse_d     = 1'b1;
                        rcnt_d      = '0;
                        rep_first_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            REL_CHK: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (dcnt_q == DB_LAST) begin
                    state_d     = IDLE;
                    rcnt_d      = '0;
                    rep_first_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!repeat_en) begin
            rcnt_d      = '0;
            rep_first_d = 1'b0;
        end

        count_d = count_q + CNT_W'(pulse_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            rcnt_q      <= '0;
            rep_first_q <= 1'b0;
            pulse_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            rcnt_q      <= rcnt_d;
            rep_first_q <= rep_first_d;
            pulse_q     <= pulse_d;
            count_q     <= count_d;
        end
    end

    assign step_pulse  = pulse_q;
    assign btn_level   = (state_q == PRESSED) || (state_q == REL_CHK);
    assign press_count = count_q;

endmodule
